// File: rtl/xbar_bank_arb_if.sv
// Request/response bundle between the crossbar channel buffers and one bank arbiter.
// The slave modport is the arbiter's view; master is the view of whoever drives the requests.
interface xbar_bank_arb_if #(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DW     = 64
);
  logic [NUM_CH-1:0]    in_valid;
  logic [NUM_CH-1:0]    in_ready;
  logic [NUM_CH*DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;
  logic [NUM_CH-1:0]    out_ch_1hot;
  logic                 starve_event;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch_1hot, starve_event
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch_1hot, starve_event
  );
endinterface

// File: rtl/xbar_bank_arb.sv
// Per-bank round-robin arbiter with starvation override, feeding a single-entry
// registered output stage toward the bank pipeline.
module xbar_bank_arb #(
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned DW         = 64,
  parameter int unsigned STARVE_MAX = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  xbar_bank_arb_if.slave   bus
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam int unsigned IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CW-1:0] CntMax = CW'(STARVE_MAX);

  logic                       out_valid_q, out_valid_d;
  logic [DW-1:0]              out_data_q, out_data_d;
  logic [NUM_CH-1:0]          out_ch_q, out_ch_d;
  logic                       starve_q, starve_d;
  logic [IW-1:0]              rr_last_q, rr_last_d;
  logic [NUM_CH-1:0][CW-1:0]  wait_q, wait_d;

  logic              can_load;
  logic              starve_found;
  logic [IW-1:0]     starve_idx;
  logic [IW-1:0]     rr_idx;
  logic [IW-1:0]     win_idx;
  logic [NUM_CH-1:0] grant;
  int unsigned       idx;

  // Arbitration: starved requester (lowest index) first, otherwise round-robin after rr_last.
  always_comb begin
    can_load     = !out_valid_q || bus.out_ready;
    starve_found = 1'b0;
    starve_idx   = '0;
    rr_idx       = '0;
    idx          = 0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (bus.in_valid[i] && (wait_q[i] == CntMax)) begin
        starve_found = 1'b1;
        starve_idx   = IW'(i);
      end
    end
    // Descending offset so the nearest valid channel after rr_last wins.
    for (int unsigned k = NUM_CH; k >= 1; k--) begin
      idx = (32'(rr_last_q) + k) % NUM_CH;
      if (bus.in_valid[idx]) begin
        rr_idx = IW'(idx);
      end
    end
    win_idx = starve_found ? starve_idx : rr_idx;
    grant   = '0;
    if (can_load && (|bus.in_valid)) begin
      grant[win_idx] = 1'b1;
    end
    bus.in_ready = grant;
  end

  // Output stage load/drain, round-robin pointer and per-channel wait counters.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    starve_d    = 1'b0;
    rr_last_d   = rr_last_q;
    wait_d      = wait_q;
    if (|grant) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.in_data[32'(win_idx)*DW +: DW];
      out_ch_d    = grant;
      starve_d    = starve_found;
      rr_last_d   = win_idx;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!bus.in_valid[i] || grant[i]) begin
        wait_d[i] = '0;
      end else if (wait_q[i] != CntMax) begin
        wait_d[i] = wait_q[i] + 1'b1;
      end
    end
  end

  // State registers; reset discards any held request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      starve_q    <= 1'b0;
      rr_last_q   <= IW'(NUM_CH - 1);
      wait_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      starve_q    <= starve_d;
      rr_last_q   <= rr_last_d;
      wait_q      <= wait_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_ch_1hot  = out_ch_q;
  assign bus.starve_event = starve_q;

endmodule
